// File: rtl/vga_pkg.sv
// Shared VGA constants, axis state type and the per-axis bounce step.
// Pure declarations and one combinational helper, no timing of its own.
// No flow control: values are consumed combinationally by the sprite logic.
package vga_pkg;

   localparam int COORD_W      = 10;
   localparam int RGB_W        = 12;
   // Motion arithmetic runs one bit wider than a coordinate so sums never wrap.
   localparam int POS_W        = COORD_W + 1;
   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;

   localparam logic [RGB_W-1:0] BLACK = 12'h000;
   localparam logic [RGB_W-1:0] RED   = 12'hF00;
   localparam logic [RGB_W-1:0] GREEN = 12'h0F0;
   localparam logic [RGB_W-1:0] BLUE  = 12'h00F;

   // One axis of a sprite: position of the top/left edge and direction
   // (0 = increasing coordinate, 1 = decreasing).
   typedef struct packed {
      logic [COORD_W-1:0] pos;
      logic               dir;
   } axis_t;

   // Advance one axis by s pixels, clamping at either edge and reversing there.
   // The caller must not invoke this with s = 0: the right/bottom clamp test
   // would otherwise fire on a square already parked against the far edge.
   function automatic axis_t axis_step(input axis_t            cur,
                                       input logic [3:0]       s,
                                       input logic [POS_W-1:0] limit,
                                       input logic [POS_W-1:0] size);
      logic [POS_W-1:0] p;
      logic [POS_W-1:0] s_w;
      axis_t            r;
      r   = cur;
      p   = {1'b0, cur.pos};
      s_w = {{(POS_W-4){1'b0}}, s};
      if (!cur.dir) begin
         if (p + size + s_w >= limit) begin
            r.pos = COORD_W'(limit - size);
            r.dir = 1'b1;
         end else begin
            r.pos = COORD_W'(p + s_w);
         end
      end else begin
         if (p <= s_w) begin
            r.pos = '0;
            r.dir = 1'b0;
         end else begin
            r.pos = COORD_W'(p - s_w);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sprite_mover.sv
// Position/direction state of one square, stepped once per enabled frame.
// New position visible the cycle after step; render sees the old one meanwhile.
// No backpressure: step is a one-cycle strobe and is always accepted.
module sprite_mover
   import vga_pkg::*;
#(
   parameter int   SIZE     = 20,
   parameter int   H_ACTIVE = H_ACTIVE_DEF,
   parameter int   V_ACTIVE = V_ACTIVE_DEF,
   parameter int   INIT_X   = 0,
   parameter int   INIT_Y   = 0,
   parameter logic INIT_DRY = 1'b0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               step,
   input  logic               flip,
   input  logic [3:0]         speed,
   output logic [COORD_W-1:0] sqx,
   output logic [COORD_W-1:0] sqy
);

   localparam logic [POS_W-1:0] SIZE_W = POS_W'(SIZE);
   localparam logic [POS_W-1:0] H_LIM  = POS_W'(H_ACTIVE);
   localparam logic [POS_W-1:0] V_LIM  = POS_W'(V_ACTIVE);

   axis_t x_q, x_d;
   axis_t y_q, y_d;
   axis_t x_in, y_in;

   // Next position: a collision flip is applied to the directions first, then
   // the edge clamp runs on the flipped direction so it always has the last word.
   // Speed 0 freezes the square entirely, flip included.
   always_comb begin
      x_d  = x_q;
      y_d  = y_q;
      x_in = x_q;
      y_in = y_q;
      x_in.dir = x_q.dir ^ flip;
      y_in.dir = y_q.dir ^ flip;
      if (step && (speed != 4'd0)) begin
         x_d = axis_step(x_in, speed, H_LIM, SIZE_W);
         y_d = axis_step(y_in, speed, V_LIM, SIZE_W);
      end
   end

   // State register; reset places the square at its staggered start point.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q <= '{pos: COORD_W'(INIT_X), dir: 1'b0};
         y_q <= '{pos: COORD_W'(INIT_Y), dir: INIT_DRY};
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign sqx = x_q.pos;
   assign sqy = y_q.pos;

endmodule

// File: rtl/bounce_sprites.sv
// Renders NUM_SPRITES bouncing squares for 640x480 VGA; SPRITE_COLLIDE_EN adds pair collisions.
// vga is registered: colour for (x,y) appears one clk later; motion updates on frame_tick.
// No backpressure: pixels stream every clock, frame_tick ignored while pause is high.
module bounce_sprites
   import vga_pkg::*;
#(
   parameter int                 NUM_SPRITES   = 4,
   parameter int                 SIZE          = 20,
   parameter int                 H_ACTIVE      = H_ACTIVE_DEF,
   parameter int                 V_ACTIVE      = V_ACTIVE_DEF,
   parameter logic [RGB_W-1:0]   BG_COLOR      = BLACK,
   // Sprite i colour lives at bits [12*i +: 12]; sprite 0 is red, 1 green, 2 blue, 3 yellow.
   parameter logic [RGB_W*8-1:0] SPRITE_COLORS = {12'h888, 12'hFFF, 12'h0FF, 12'hF0F,
                                                  12'hFF0, 12'h00F, 12'h0F0, 12'hF00}
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic               frame_tick,
   input  logic [3:0]         speed,
   input  logic               pause,
   output logic [RGB_W-1:0]   vga,
   output logic [15:0]        collision_cnt
);

   localparam logic [POS_W-1:0] SIZE_W = POS_W'(SIZE);
   localparam logic [POS_W-1:0] H_LIM  = POS_W'(H_ACTIVE);
   localparam logic [POS_W-1:0] V_LIM  = POS_W'(V_ACTIVE);

   // Start positions are staggered, so the screen must hold the whole diagonal.
   if (NUM_SPRITES < 1 || NUM_SPRITES > 8) begin : g_bad_num
      $error("bounce_sprites: NUM_SPRITES must be 1..8");
   end
   if (NUM_SPRITES * 2 * SIZE > H_ACTIVE) begin : g_bad_h
      $error("bounce_sprites: NUM_SPRITES*2*SIZE exceeds H_ACTIVE");
   end
   if (NUM_SPRITES * SIZE > V_ACTIVE) begin : g_bad_v
      $error("bounce_sprites: NUM_SPRITES*SIZE exceeds V_ACTIVE");
   end

   logic                   step;
   logic [COORD_W-1:0]     sqx [NUM_SPRITES];
   logic [COORD_W-1:0]     sqy [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] flip;
   logic [NUM_SPRITES-1:0] hit;
   logic [RGB_W-1:0]       vga_d, vga_q;

   assign step = frame_tick & ~pause;

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
      sprite_mover #(
         .SIZE     (SIZE),
         .H_ACTIVE (H_ACTIVE),
         .V_ACTIVE (V_ACTIVE),
         .INIT_X   (g * 2 * SIZE),
         .INIT_Y   (g * SIZE),
         .INIT_DRY ((g % 2) == 1)
      ) u_mover (
         .clk     (clk),
         .reset_n (reset_n),
         .step    (step),
         .flip    (flip[g]),
         .speed   (speed),
         .sqx     (sqx[g]),
         .sqy     (sqy[g])
      );
   end

   // Per-sprite hit test against the current (pre-update) positions.
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         hit[i] = ({1'b0, x} >= {1'b0, sqx[i]}) && ({1'b0, x} < {1'b0, sqx[i]} + SIZE_W) &&
                  ({1'b0, y} >= {1'b0, sqy[i]}) && ({1'b0, y} < {1'b0, sqy[i]} + SIZE_W);
      end
   end

   // Colour select: scan high to low so the lowest-index hit wins; blanking forces 0.
   always_comb begin
      vga_d = BG_COLOR;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (hit[i]) begin
            vga_d = SPRITE_COLORS[RGB_W*i +: RGB_W];
         end
      end
      if (({1'b0, x} >= H_LIM) || ({1'b0, y} >= V_LIM)) begin
         vga_d = '0;
      end
   end

   // Output colour register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vga_q <= '0;
      end else begin
         vga_q <= vga_d;
      end
   end

   assign vga = vga_q;

`ifdef SPRITE_COLLIDE_EN
   logic [4:0]  pair_cnt;
   logic [16:0] cnt_sum;
   logic [15:0] cnt_d, cnt_q;

   // Pairwise overlap on pre-update positions; a sprite in several pairs still
   // flips only once because flip is an OR over its pairs.
   always_comb begin
      pair_cnt = '0;
      flip     = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         for (int j = i + 1; j < NUM_SPRITES; j++) begin
            if (({1'b0, sqx[i]} < {1'b0, sqx[j]} + SIZE_W) &&
                ({1'b0, sqx[j]} < {1'b0, sqx[i]} + SIZE_W) &&
                ({1'b0, sqy[i]} < {1'b0, sqy[j]} + SIZE_W) &&
                ({1'b0, sqy[j]} < {1'b0, sqy[i]} + SIZE_W)) begin
               pair_cnt = pair_cnt + 5'd1;
               flip[i]  = 1'b1;
               flip[j]  = 1'b1;
            end
         end
      end
      if (!step) begin
         flip = '0;
      end
   end

   // Saturating collision counter, advanced only on update cycles.
   always_comb begin
      cnt_d   = cnt_q;
      cnt_sum = {1'b0, cnt_q} + 17'(pair_cnt);
      if (step) begin
         cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      end
   end

   // Collision counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign collision_cnt = cnt_q;
`else
   assign flip          = '0;
   assign collision_cnt = 16'h0;
`endif

endmodule
